// File: rtl/wave_gen.sv
// Up/down wave generator: triangle, saw up, saw down or hold between runtime bounds.
// Optional output ceiling enabled by defining WAVE_GEN_CLIP_EN.
module wave_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] wave,
  output logic             dir,
  output logic             peak,
  output logic             trough
);

  localparam int unsigned XW = WIDTH + 1;

  localparam logic [1:0] MODE_TRI  = 2'd0;
  localparam logic [1:0] MODE_UP   = 2'd1;
  localparam logic [1:0] MODE_DOWN = 2'd2;

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_n;
  logic             dir_n;

  // One extra bit on every sum and difference so the comparisons never see a wrap.
  logic [XW-1:0] c_x, lo_x, hi_x, st_x, up_x, dn_x, lo_st_x;

  assign c_x     = {1'b0, count};
  assign lo_x    = {1'b0, lo};
  assign hi_x    = {1'b0, hi};
  assign st_x    = {1'b0, step};
  assign up_x    = c_x + st_x;
  assign dn_x    = c_x - st_x;
  assign lo_st_x = lo_x + st_x;

  always_comb begin
    count_n = count;
    dir_n   = dir;
    if (lo >= hi) begin
      count_n = lo;
      dir_n   = 1'b0;
    end else if (count < lo) begin
      count_n = lo;
      dir_n   = 1'b0;
    end else if (count > hi) begin
      count_n = hi;
      if (mode == MODE_TRI) dir_n = 1'b1;
    end else begin
      case (mode)
        MODE_TRI: begin
          if (!dir) begin
            if (up_x >= hi_x) begin
              count_n = hi;
              dir_n   = 1'b1;
            end else begin
              count_n = WIDTH'(up_x);
            end
          end else begin
            if (c_x <= lo_st_x) begin
              count_n = lo;
              dir_n   = 1'b0;
            end else begin
              count_n = WIDTH'(dn_x);
            end
          end
        end
        MODE_UP: begin
          dir_n = 1'b0;
          if (count == hi)       count_n = lo;
          else if (up_x > hi_x)  count_n = hi;
          else                   count_n = WIDTH'(up_x);
        end
        MODE_DOWN: begin
          dir_n = 1'b1;
          if (count == lo)          count_n = hi;
          else if (c_x < lo_st_x)   count_n = lo;
          else                      count_n = WIDTH'(dn_x);
        end
        default: begin
          count_n = count;
          dir_n   = dir;
        end
      endcase
    end
  end

  // Pulses only mark a real arrival at an extreme, never a hold on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      dir    <= 1'b0;
      peak   <= 1'b0;
      trough <= 1'b0;
    end else if (en) begin
      count  <= count_n;
      dir    <= dir_n;
      peak   <= (count_n == hi) && (count_n != count);
      trough <= (count_n == lo) && (count_n != count);
    end else begin
      peak   <= 1'b0;
      trough <= 1'b0;
    end
  end

`ifdef WAVE_GEN_CLIP_EN
  assign wave = (count < max) ? count : max;
`else
  logic unused_max;
  assign unused_max = ^max;
  assign wave = count;
`endif

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: vector table, directed corner sequences and
// randomized stimulus against a rule-level reference model.
module tb_wave_gen;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [1:0]   mode;
  logic [W-1:0] lo, hi, step, max;
  logic [W-1:0] wave;
  logic         dir, peak, trough;

  wave_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .lo(lo), .hi(hi),
    .step(step), .max(max), .wave(wave), .dir(dir), .peak(peak), .trough(trough)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  int m_count = 0;
  bit m_dir = 1'b0, m_peak = 1'b0, m_trough = 1'b0;

  typedef struct {
    logic         rst, en;
    logic [1:0]   mode;
    logic [W-1:0] lo, hi, step;
    int           e_wave;
    bit           e_dir, e_peak, e_trough;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int clipw(input int c);
`ifdef WAVE_GEN_CLIP_EN
    return (c < int'(max)) ? c : int'(max);
`else
    return c;
`endif
  endfunction

  // Reference model: the operating rules evaluated in plain integer arithmetic.
  task automatic model_edge();
    int c, l, h, s, n;
    bit d;
    c = m_count; l = int'(lo); h = int'(hi); s = int'(step); d = m_dir; n = c;
    if (rst) begin
      m_count = 0; m_dir = 0; m_peak = 0; m_trough = 0;
      return;
    end
    if (!en) begin
      m_peak = 0; m_trough = 0;
      return;
    end
    if (l >= h)     begin n = l; d = 0; end
    else if (c < l) begin n = l; d = 0; end
    else if (c > h) begin n = h; if (mode == 2'd0) d = 1; end
    else if (mode == 2'd0) begin
      if (!d) begin
        if (c + s >= h) begin n = h; d = 1; end else n = c + s;
      end else begin
        if (c <= l + s) begin n = l; d = 0; end else n = c - s;
      end
    end else if (mode == 2'd1) begin
      d = 0;
      n = (c == h) ? l : ((c + s > h) ? h : c + s);
    end else if (mode == 2'd2) begin
      d = 1;
      n = (c == l) ? h : ((c < l + s) ? l : c - s);
    end
    m_peak   = (n == h) && (n != c);
    m_trough = (n == l) && (n != c);
    m_count  = n;
    m_dir    = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_wave",   int'(wave),   clipw(m_count));
    check("model_dir",    int'(dir),    int'(m_dir));
    check("model_peak",   int'(peak),   int'(m_peak));
    check("model_trough", int'(trough), int'(m_trough));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_tri(input logic [W-1:0] l, input logic [W-1:0] h, input logic [W-1:0] s);
    en = 1'b1; mode = 2'd0; lo = l; hi = h; step = s;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; lo = '0; hi = '0; step = '0; max = 4'd15;

    do_reset();
    check("reset_wave",   int'(wave),   0);
    check("reset_dir",    int'(dir),    0);
    check("reset_peak",   int'(peak),   0);
    check("reset_trough", int'(trough), 0);

    // Saw up 2..10 step 3, then saw down 3..9 step 4, each from reset.
    vecs[0]  = '{1'b0, 1'b1, 2'd1, 4'd2, 4'd10, 4'd3, 2,  1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 4'd2, 4'd10, 4'd3, 5,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 4'd2, 4'd10, 4'd3, 8,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 4'd2, 4'd10, 4'd3, 10, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 4'd2, 4'd10, 4'd3, 2,  1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 4'd2, 4'd10, 4'd3, 5,  1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'd2, 4'd3, 4'd9,  4'd4, 0,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 4'd3, 4'd9,  4'd4, 3,  1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 4'd3, 4'd9,  4'd4, 9,  1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 4'd3, 4'd9,  4'd4, 5,  1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 4'd3, 4'd9,  4'd4, 3,  1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 4'd3, 4'd9,  4'd4, 9,  1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 2'd2, 4'd3, 4'd9,  4'd4, 9,  1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
      lo = vecs[i].lo; hi = vecs[i].hi; step = vecs[i].step;
      tick();
      check($sformatf("vec%0d_wave", i),   int'(wave),   vecs[i].e_wave);
      check($sformatf("vec%0d_dir", i),    int'(dir),    int'(vecs[i].e_dir));
      check($sformatf("vec%0d_peak", i),   int'(peak),   int'(vecs[i].e_peak));
      check($sformatf("vec%0d_trough", i), int'(trough), int'(vecs[i].e_trough));
    end
    rst = 1'b0;

    // Full triangle 0..15..0 step 1, period 30.
`ifdef WAVE_GEN_CLIP_EN
    max = 4'd9;
`endif
    en = 1'b0;
    do_reset();
    set_tri(4'd0, 4'd15, 4'd1);
    for (int k = 1; k <= 30; k++) begin
      int cnt;
      cnt = (k <= 15) ? k : 30 - k;
      tick();
`ifdef WAVE_GEN_CLIP_EN
      check("tri_wave", int'(wave), (cnt < 9) ? cnt : 9);
`else
      check("tri_wave", int'(wave), cnt);
`endif
      check("tri_peak",   int'(peak),   (k == 15) ? 1 : 0);
      check("tri_trough", int'(trough), (k == 30) ? 1 : 0);
    end
    max = 4'd15;

    // Enable gap mid-ramp at 7.
    en = 1'b0;
    do_reset();
    set_tri(4'd0, 4'd15, 4'd1);
    repeat (7) tick();
    check("en_pre_wave", int'(wave), 7);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("en_hold_wave",   int'(wave),   7);
      check("en_hold_peak",   int'(peak),   0);
      check("en_hold_trough", int'(trough), 0);
    end
    en = 1'b1;
    tick();
    check("en_resume_wave", int'(wave), 8);

    // Lower hi below count, then collapse bounds.
    en = 1'b0;
    do_reset();
    set_tri(4'd0, 4'd15, 4'd1);
    repeat (12) tick();
    check("hi_pre_wave", int'(wave), 12);
    hi = 4'd6;
    tick();
    check("hi_drop_wave", int'(wave), 6);
    check("hi_drop_dir",  int'(dir),  1);
    check("hi_drop_peak", int'(peak), 1);
    lo = 4'd4; hi = 4'd4;
    tick();
    check("degen_wave", int'(wave), 4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("degen_hold_wave",   int'(wave),   4);
      check("degen_hold_peak",   int'(peak),   0);
      check("degen_hold_trough", int'(trough), 0);
    end

    // Randomized stimulus against the reference model.
    en = 1'b0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        mode = 2'($urandom_range(0, 3));
        lo   = W'($urandom_range(0, 15));
        hi   = W'($urandom_range(0, 15));
        step = W'($urandom_range(0, 6));
        max  = W'($urandom_range(0, 15));
      end
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
